// File: rtl/scc_decode_result_buffer.sv
// scc_decode_result_buffer
//   Small valid/ready FIFO that buffers SCC 4LC decoder results, tags each entry
//   with a poison bit, and keeps saturating corrected / uncorrectable error counts
//   plus a sticky uncorrectable-error interrupt flag.
//
// Parameters
//   DEPTH  FIFO entries, power of two in 2..16
//   CNT_W  width of each error counter
//
// Ports
//   clk, rst                   clock, asynchronous active-high reset
//   in_valid/in_ready          input handshake
//   in_message, in_error_type  decoder result (00 ok, 01 ce, 10 due, 11 reserved)
//   out_valid/out_ready        output handshake
//   out_message, out_poison    head entry
//   ce_count, due_count        saturating error counters
//   cnt_clear                  synchronous clear of both counters
//   due_irq, irq_clear         sticky uncorrectable flag and its clear
module scc_decode_result_buffer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [63:0]      in_message,
  input  logic [1:0]       in_error_type,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_message,
  output logic             out_poison,
  output logic [CNT_W-1:0] ce_count,
  output logic [CNT_W-1:0] due_count,
  input  logic             cnt_clear,
  output logic             due_irq,
  input  logic             irq_clear
);

  localparam int unsigned Aw = $clog2(DEPTH);

  typedef logic [Aw-1:0] ptr_t;
  typedef logic [Aw:0]   occ_t;
  typedef logic [CNT_W-1:0] cnt_t;

  localparam occ_t Full   = occ_t'(DEPTH);
  localparam cnt_t CntMax = {CNT_W{1'b1}};

  // Each entry is {poison, message}.
  logic [64:0] mem_q [DEPTH];

  ptr_t wr_ptr_q, wr_ptr_d;
  ptr_t rd_ptr_q, rd_ptr_d;
  occ_t count_q, count_d;
  cnt_t ce_q, ce_d;
  cnt_t due_q, due_d;
  logic irq_q, irq_d;

  logic accept;
  logic pop;
  logic ce_inc;
  logic due_inc;

  // Handshake flags depend only on registered occupancy, so there is no
  // combinational path from out_ready to in_ready or from input to output.
  assign in_ready  = (count_q != Full);
  assign out_valid = (count_q != '0);

  assign accept  = in_valid & in_ready;
  assign pop     = out_valid & out_ready;
  assign ce_inc  = accept & (in_error_type == 2'b01);
  assign due_inc = accept & in_error_type[1];

  // Head entry only changes on a pop; writes never target the head slot while
  // it is occupied because a full FIFO refuses writes.
  assign out_message = mem_q[rd_ptr_q][63:0];
  assign out_poison  = mem_q[rd_ptr_q][64];

  assign ce_count  = ce_q;
  assign due_count = due_q;
  assign due_irq   = irq_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // DEPTH is a power of two, so natural pointer overflow wraps DEPTH-1 -> 0.
    if (accept) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)    rd_ptr_d = rd_ptr_q + 1'b1;
    if (accept && !pop) begin
      count_d = count_q + 1'b1;
    end else if (!accept && pop) begin
      count_d = count_q - 1'b1;
    end
  end

  always_comb begin
    ce_d  = ce_q;
    due_d = due_q;
    irq_d = irq_q;
    // A clear coinciding with an event keeps that event counted.
    if (cnt_clear) begin
      ce_d  = ce_inc  ? cnt_t'(1) : '0;
      due_d = due_inc ? cnt_t'(1) : '0;
    end else begin
      if (ce_inc  && (ce_q  != CntMax)) ce_d  = ce_q  + 1'b1;
      if (due_inc && (due_q != CntMax)) due_d = due_q + 1'b1;
    end
    // Set has priority over clear.
    if (due_inc) begin
      irq_d = 1'b1;
    end else if (irq_clear) begin
      irq_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ce_q     <= '0;
      due_q    <= '0;
      irq_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ce_q     <= ce_d;
      due_q    <= due_d;
      irq_q    <= irq_d;
    end
  end

  // Storage needs no reset: contents are invisible while out_valid is low.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem_q[wr_ptr_q] <= {in_error_type[1], in_message};
    end
  end

endmodule

// File: tb/tb_scc_decode_result_buffer.sv
module tb_scc_decode_result_buffer;

  localparam int unsigned Depth = 4;
  localparam int unsigned CntW  = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [63:0]     in_message;
  logic [1:0]      in_error_type;
  logic            out_valid;
  logic            out_ready;
  logic [63:0]     out_message;
  logic            out_poison;
  logic [CntW-1:0] ce_count;
  logic [CntW-1:0] due_count;
  logic            cnt_clear;
  logic            due_irq;
  logic            irq_clear;

  int n_checks = 0;
  int n_fail   = 0;
  int n_pops   = 0;

  // Expected entries as {poison, message}.
  logic [64:0] sb [$];

  scc_decode_result_buffer #(
    .DEPTH (Depth),
    .CNT_W (CntW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_message    (in_message),
    .in_error_type (in_error_type),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_message   (out_message),
    .out_poison    (out_poison),
    .ce_count      (ce_count),
    .due_count     (due_count),
    .cnt_clear     (cnt_clear),
    .due_irq       (due_irq),
    .irq_clear     (irq_clear)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Handshakes are resolved at the falling edge; inputs only move just after a rising edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("pop_unexpected", 64'(out_valid), 64'd0);
        end else begin
          logic [64:0] e;
          e = sb.pop_front();
          check("pop_message", out_message, e[63:0]);
          check("pop_poison", 64'(out_poison), 64'(e[64]));
        end
        n_pops++;
      end
      if (in_valid && in_ready) begin
        sb.push_back({in_error_type[1], in_message});
      end
    end
  end

  task automatic send(input logic [63:0] m, input logic [1:0] t);
    int n;
    n = 0;
    in_valid      = 1'b1;
    in_message    = m;
    in_error_type = t;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("accept_wait", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid      = 1'b0;
    in_message    = {$urandom, $urandom};
    in_error_type = 2'($urandom);
  endtask

  task automatic drain();
    int n;
    n = 0;
    out_ready = 1'b1;
    @(negedge clk);
    while (out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain_empty", 64'(out_valid), 64'd0);
    check("drain_sb_empty", 64'(sb.size()), 64'd0);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    rst = 1'b1;
    in_valid = 1'b0;
    in_message = '0;
    in_error_type = '0;
    out_ready = 1'b0;
    cnt_clear = 1'b0;
    irq_clear = 1'b0;
    #3;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_ce", 64'(ce_count), 64'd0);
    check("rst_due", 64'(due_count), 64'd0);
    check("rst_irq", 64'(due_irq), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    step();

    // Single corrected beat, visible one cycle later.
    send(64'h0123_4567_89AB_CDEF, 2'b01);
    check("single_valid", 64'(out_valid), 64'd1);
    check("single_message", out_message, 64'h0123_4567_89AB_CDEF);
    check("single_poison", 64'(out_poison), 64'd0);
    check("single_ce", 64'(ce_count), 64'd1);
    drain();

    // Fill to full, then a fifth beat waits for space.
    p0 = n_pops;
    for (int i = 0; i < 4; i++) send(64'hA0 + 64'(i), 2'b00);
    in_valid = 1'b1;
    in_message = 64'hA4;
    in_error_type = 2'b00;
    @(negedge clk);
    check("full_no_ready", 64'(in_ready), 64'd0);
    check("hold_head", out_message, 64'hA0);
    step();
    check("hold_head_again", out_message, 64'hA0);
    out_ready = 1'b1;
    @(negedge clk);
    check("full_with_out_ready", 64'(in_ready), 64'd0);
    begin
      int n;
      n = 0;
      while (!in_ready && n < 20) begin
        @(negedge clk);
        n++;
      end
      check("fifth_accept_wait", 64'(in_ready), 64'd1);
    end
    step();
    in_valid = 1'b0;
    drain();
    check("fill_pop_count", 64'(n_pops - p0), 64'd5);

    // Uncorrectable and reserved results are poisoned and raise the irq.
    send(64'hDEAD_0001, 2'b10);
    send(64'hDEAD_0002, 2'b11);
    check("due_two", 64'(due_count), 64'd2);
    check("irq_set", 64'(due_irq), 64'd1);
    irq_clear = 1'b1;
    send(64'hDEAD_0003, 2'b10);
    irq_clear = 1'b0;
    check("irq_set_wins", 64'(due_irq), 64'd1);
    check("due_three", 64'(due_count), 64'd3);
    irq_clear = 1'b1;
    step();
    irq_clear = 1'b0;
    check("irq_cleared", 64'(due_irq), 64'd0);
    drain();

    // Saturation of the corrected counter, then clear racing an increment.
    cnt_clear = 1'b1;
    step();
    cnt_clear = 1'b0;
    check("cnt_cleared", 64'(ce_count), 64'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) send(64'hC000 + 64'(i), 2'b01);
    check("ce_saturated", 64'(ce_count), 64'd15);
    cnt_clear = 1'b1;
    send(64'hC0FF, 2'b01);
    cnt_clear = 1'b0;
    check("ce_clear_with_inc", 64'(ce_count), 64'd1);
    check("due_clear_no_inc", 64'(due_count), 64'd0);
    drain();

    // Steady accept+pop at occupancy two; pointers wrap several times.
    send(64'hB0, 2'b00);
    send(64'hB1, 2'b00);
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      send(64'hB2 + 64'(i), 2'b01);
      check("steady_valid", 64'(out_valid), 64'd1);
    end
    p0 = n_pops;
    drain();
    check("steady_occupancy", 64'(n_pops - p0), 64'd2);

    // Asynchronous reset mid-cycle with three entries held.
    send(64'hE0, 2'b01);
    send(64'hE1, 2'b10);
    send(64'hE2, 2'b01);
    check("pre_rst_valid", 64'(out_valid), 64'd1);
    #2;
    rst = 1'b1;
    sb.delete();
    #1;
    check("arst_out_valid", 64'(out_valid), 64'd0);
    check("arst_in_ready", 64'(in_ready), 64'd1);
    check("arst_ce", 64'(ce_count), 64'd0);
    check("arst_due", 64'(due_count), 64'd0);
    check("arst_irq", 64'(due_irq), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    step();
    send(64'hF00D, 2'b00);
    check("post_rst_valid", 64'(out_valid), 64'd1);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/scc_decode_result_buffer.md
SCC_DECODE_RESULT_BUFFER -- requirements
Module: scc_decode_result_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning FIFO entries (power of two, 2..16).
REQ-002 SHALL have parameter CNT_W, default 16, meaning width of each error counter.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1, meaning a decoder result is presented.
REQ-006 SHALL have port in_ready, output, 1, meaning the buffer can accept a result.
REQ-007 SHALL have port in_message, input, 64, the corrected message from the SCC 4LC decoder.
REQ-008 SHALL have port in_error_type, input, 2, the decoder status: 00 no error, 01 corrected, 10 uncorrectable, 11 reserved.
REQ-009 SHALL have port out_valid, output, 1, meaning the head entry is valid.
REQ-010 SHALL have port out_ready, input, 1, meaning the consumer accepts the head entry.
REQ-011 SHALL have port out_message, output, 64, the head-entry message.
REQ-012 SHALL have port out_poison, output, 1, high when the head entry was uncorrectable or reserved.
REQ-013 SHALL have port ce_count, output, CNT_W, the corrected-error count.
REQ-014 SHALL have port due_count, output, CNT_W, the uncorrectable-error count.
REQ-015 SHALL have port cnt_clear, input, 1, a synchronous clear of both counters.
REQ-016 SHALL have port due_irq, output, 1, a sticky uncorrectable-error flag.
REQ-017 SHALL have port irq_clear, input, 1, a synchronous clear of due_irq.

Function
REQ-018 SHALL accept a beat only when in_valid and in_ready are both 1 in the same cycle.
REQ-019 SHALL pop the head entry only when out_valid and out_ready are both 1 in the same cycle.
REQ-020 SHALL drive in_ready = 1 iff occupancy < DEPTH, with no combinational dependence on out_ready.
REQ-021 SHALL drive out_valid = 1 iff occupancy > 0; latency from accept to out_valid is 1 cycle when empty, with no combinational in-to-out bypass.
REQ-022 SHALL store message and poison per entry; poison = (in_error_type == 10 or 11).
REQ-023 SHALL implement the FIFO as circular read/write pointers of log2(DEPTH) bits that wrap DEPTH-1 -> 0, plus an occupancy counter of log2(DEPTH)+1 bits.
REQ-024 SHALL, on a simultaneous accept and pop at occupancy 1..DEPTH-1, leave occupancy unchanged and advance both pointers.
REQ-025 SHALL, when full, drop in_ready even when out_ready is high in that cycle; the write happens no earlier than the cycle after the pop.
REQ-026 SHALL hold out_message and out_poison stable while out_valid = 1 and out_ready = 0.
REQ-027 SHALL increment ce_count on each accepted beat with error_type 01, and due_count on each accepted beat with error_type 10 or 11.
REQ-028 SHALL saturate each counter at 2^CNT_W-1 with no wrap.
REQ-029 SHALL, when cnt_clear is 1, set a counter to 1 if that counter's increment event occurs in the same cycle, and otherwise to 0.
REQ-030 SHALL set due_irq on any accepted beat with error_type 10 or 11; irq_clear clears it; set wins when both occur in the same cycle.
REQ-031 SHALL ignore in_message and in_error_type in cycles without an accept.

Reset
REQ-032 SHALL, while rst = 1, asynchronously force pointers and occupancy to 0, out_valid 0, in_ready 1, ce_count 0, due_count 0, and due_irq 0.
REQ-033 SHALL discard all entries on reset, including a reset asserted mid-transfer; out_message and out_poison are don't-care while out_valid = 0.
REQ-034 SHALL resume accepting on the first rising clk edge after rst deasserts.

Verification
REQ-035 SHALL cover: after reset, a single beat with message 64'h0123_4567_89AB_CDEF and type 01 -> out_valid 1 the next cycle with that message, out_poison 0, ce_count 1.
REQ-036 SHALL cover: out_ready held 0 with 5 beats offered at DEPTH=4 -> in_ready 0 after 4 accepts; out_ready then held 1 -> 4 pops in order, followed by the 5th beat.
REQ-037 SHALL cover: type 10 then type 11 accepted -> due_count 2, due_irq 1, both entries with out_poison 1; irq_clear pulsed together with a type-10 accept -> due_irq stays 1.
REQ-038 SHALL cover: ce_count forced to saturation at CNT_W=4 by 20 type-01 beats -> ce_count 15; cnt_clear together with a type-01 accept -> ce_count 1.
REQ-039 SHALL cover: continuous accept and pop at occupancy 2 for 10 cycles -> occupancy stays 2, pointers wrap, data order preserved.
REQ-040 SHALL cover: rst asserted asynchronously mid-cycle with 3 entries held -> out_valid 0, counters 0, and in_ready 1 immediately, before the next clk edge.
